// File: rtl/binarization_pkg.sv
// ============================================================================
// Module  : binarization_pkg
// Brief   : Shared types and sizing helpers for the adaptive binarizer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package binarization_pkg;

  // Sizes for the default build (8-bit luminance, 22-bit pixel counter).
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 22;

  // Accumulator width, and the serial divider needs one cycle per bit of it.
  localparam int ACC_W   = DATA_W_DEF + CNT_W_DEF;
  localparam int DIV_CYC = ACC_W;

  // Threshold-estimation state machine.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DIVIDE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Accumulator width for an arbitrary parameterisation.
  function automatic int acc_width(input int data_w, input int cnt_w);
    return data_w + cnt_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/binarization_adaptive_div.sv
// ============================================================================
// Module  : serial_div_u
// Brief   : Restoring unsigned divider, one quotient bit per cycle. The first
//           bit is produced in the start cycle, so a full N_W-bit division
//           takes exactly N_W cycles. The quotient output is saturated to Q_W
//           bits and stays valid after done until the next start.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_div_u #(
  parameter int N_W = 30,
  parameter int D_W = 22,
  parameter int Q_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           busy,
  output logic           done,
  output logic [Q_W-1:0] quotient
);

  localparam int             L_W        = $clog2(N_W + 1);
  localparam logic [L_W-1:0] STEPS_LEFT = L_W'(N_W - 1);
  localparam logic [L_W-1:0] ONE_STEP   = L_W'(1);

  logic [N_W-1:0] quo_r, quo_src, quo_nxt;
  logic [D_W-1:0] rem_r, rem_src, rem_nxt;
  logic [D_W-1:0] dsr_r, dsr_src;
  logic [D_W:0]   trial;
  logic           fits;
  logic [L_W-1:0] left_r;

  // One restoring step; on start the step works directly on the new operands.
  always_comb begin
    quo_src = start ? dividend : quo_r;
    rem_src = start ? '0 : rem_r;
    dsr_src = start ? divisor : dsr_r;
    trial   = {rem_src, quo_src[N_W-1]};
    fits    = (trial >= {1'b0, dsr_src});
    rem_nxt = fits ? D_W'(trial - {1'b0, dsr_src}) : trial[D_W-1:0];
    quo_nxt = {quo_src[N_W-2:0], fits};
  end

  // Operand/partial-result registers and step counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      quo_r  <= '0;
      rem_r  <= '0;
      dsr_r  <= '0;
      left_r <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quo_r  <= quo_nxt;
        rem_r  <= rem_nxt;
        dsr_r  <= divisor;
        left_r <= STEPS_LEFT;
        busy   <= 1'b1;
      end else if (busy) begin
        quo_r  <= quo_nxt;
        rem_r  <= rem_nxt;
        left_r <= left_r - ONE_STEP;
        if (left_r == ONE_STEP) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // A mean never exceeds the pixel range, but clamp anyway for safety.
  assign quotient = (|quo_r[N_W-1:Q_W]) ? '1 : quo_r[Q_W-1:0];

endmodule

`default_nettype wire

// File: rtl/binarization_adaptive.sv
// ============================================================================
// Module  : binarization_adaptive
// Brief   : Per-pixel binarizer with a fixed or frame-adaptive threshold. In
//           auto mode the mean luminance of a frame becomes the threshold of
//           a later frame; all changes take effect only at a frame start.
//           Optional macro BINARIZATION_HYST_EN adds per-line hysteresis
//           around the threshold (band half-width cfg_hyst).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module binarization_adaptive
  import binarization_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 22,
  parameter int DEF_THRESH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pre_vsync,
  input  logic              pre_href,
  input  logic              pre_de,
  input  logic [DATA_W-1:0] pre_data,
  input  logic              cfg_auto,
  input  logic [DATA_W-1:0] cfg_thresh,
  input  logic              cfg_invert,
  input  logic [DATA_W-1:0] cfg_hyst,
  output logic              post_vsync,
  output logic              post_href,
  output logic              post_de,
  output logic              monoc,
  output logic [DATA_W-1:0] cur_thresh,
  output logic              thresh_upd
);

  localparam int                SUM_W   = acc_width(DATA_W, CNT_W);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [DATA_W-1:0] THR_RST = DATA_W'(DEF_THRESH);

  state_t            state;
  logic              vs_d;
  logic              vs_rise, vs_fall;
  logic              auto_l, invert_l;
  logic              acc_mode, accum_en;
  logic [SUM_W-1:0]  sum;
  logic [CNT_W-1:0]  count;
  logic              div_start, div_done, div_busy_unused;
  logic [DATA_W-1:0] div_quot;
  logic [DATA_W-1:0] pend;
  logic              pend_v;
  logic [DATA_W-1:0] next_thresh;
  logic              below, pix_val;

  assign vs_rise = pre_vsync & ~vs_d;
  assign vs_fall = ~pre_vsync & vs_d;

  // The mode latched at a frame start already governs that start cycle.
  assign acc_mode = vs_rise ? cfg_auto : auto_l;
  assign accum_en = pre_vsync & pre_de & acc_mode;

  // Operands are captured here, so the accumulator is free for the next frame.
  assign div_start = (state == ST_ACCUM) && vs_fall && (count != '0);

  // Manual mode reloads every frame; auto mode takes a finished mean if any.
  assign next_thresh = cfg_auto ? (pend_v ? pend : cur_thresh) : cfg_thresh;

  // Configuration is sampled only at frame start to keep a frame consistent.
  always_ff @(posedge clk) begin
    if (rst) begin
      auto_l   <= 1'b0;
      invert_l <= 1'b0;
    end else if (vs_rise) begin
      auto_l   <= cfg_auto;
      invert_l <= cfg_invert;
    end
  end

  // Luminance sum and pixel count; restart at every frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= '0;
      count <= '0;
    end else if (vs_rise) begin
      sum   <= accum_en ? SUM_W'(pre_data) : '0;
      count <= accum_en ? CNT_ONE : '0;
    end else if (accum_en && (count != '1)) begin
      sum   <= sum + SUM_W'(pre_data);
      count <= count + CNT_ONE;
    end
  end

  serial_div_u #(
    .N_W (SUM_W),
    .D_W (CNT_W),
    .Q_W (DATA_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (sum),
    .divisor  (count),
    .busy     (div_busy_unused),
    .done     (div_done),
    .quotient (div_quot)
  );

  // Estimation FSM and pending-mean register. A frame that ends while the
  // previous division is still running is not measured.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      pend   <= '0;
      pend_v <= 1'b0;
    end else begin
      if (vs_rise && cfg_auto) begin
        pend_v <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (vs_rise && cfg_auto) begin
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (vs_fall) begin
            state <= (count != '0) ? ST_DIVIDE : ST_IDLE;
          end
        end
        ST_DIVIDE: begin
          if (div_done) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          pend   <= div_quot;
          pend_v <= 1'b1;
          state  <= (pre_vsync && acc_mode) ? ST_ACCUM : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Threshold in use, updated only at frame start, with a change pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_thresh <= THR_RST;
      thresh_upd <= 1'b0;
    end else begin
      thresh_upd <= 1'b0;
      if (vs_rise) begin
        cur_thresh <= next_thresh;
        thresh_upd <= (next_thresh != cur_thresh);
      end
    end
  end

  assign below = (pre_data < cur_thresh);

`ifdef BINARIZATION_HYST_EN
  logic              hyst_l;
  logic [DATA_W-1:0] hyst_band;
  logic              href_d, href_rise;
  logic              prev_bit, prev_eff;
  logic [DATA_W-1:0] dist;
  logic              in_band;

  assign href_rise = pre_href & ~href_d;
  assign prev_eff  = href_rise ? 1'b0 : prev_bit;
  assign dist      = (pre_data >= cur_thresh) ? (pre_data - cur_thresh)
                                              : (cur_thresh - pre_data);
  assign in_band   = (dist <= hyst_band);
  assign pix_val   = in_band ? prev_eff : (below ^ invert_l);
  assign hyst_l    = 1'b1;

  // Hysteresis band width and last decision of the current line.
  always_ff @(posedge clk) begin
    if (rst) begin
      hyst_band <= '0;
      href_d    <= 1'b0;
      prev_bit  <= 1'b0;
    end else begin
      href_d <= pre_href;
      if (vs_rise && hyst_l) begin
        hyst_band <= cfg_hyst;
      end
      if (pre_de) begin
        prev_bit <= pix_val;
      end else if (href_rise) begin
        prev_bit <= 1'b0;
      end
    end
  end
`else
  logic unused_hyst;
  assign unused_hyst = ^cfg_hyst;
  assign pix_val     = below ^ invert_l;
`endif

  // One-cycle timing delay with the binary pixel aligned to post_de.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d       <= 1'b0;
      post_vsync <= 1'b0;
      post_href  <= 1'b0;
      post_de    <= 1'b0;
      monoc      <= 1'b0;
    end else begin
      vs_d       <= pre_vsync;
      post_vsync <= pre_vsync;
      post_href  <= pre_href;
      post_de    <= pre_de;
      monoc      <= pre_de & pix_val;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_binarization_adaptive.sv
// ============================================================================
// Module  : tb_binarization_adaptive
// Brief   : Directed bench for binarization_adaptive (default 8/22/32 build).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_binarization_adaptive;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vs  = 1'b0;
  logic       hr  = 1'b0;
  logic       de  = 1'b0;
  logic [7:0] d   = 8'd0;
  logic       aut = 1'b0;
  logic       inv = 1'b0;
  logic [7:0] th  = 8'd32;
  logic [7:0] hy  = 8'd0;

  logic       post_vsync, post_href, post_de, monoc, thresh_upd;
  logic [7:0] cur_thresh;

  int total = 0;
  int bad   = 0;

  binarization_adaptive #(
    .DATA_W     (8),
    .CNT_W      (22),
    .DEF_THRESH (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pre_vsync  (vs),
    .pre_href   (hr),
    .pre_de     (de),
    .pre_data   (d),
    .cfg_auto   (aut),
    .cfg_thresh (th),
    .cfg_invert (inv),
    .cfg_hyst   (hy),
    .post_vsync (post_vsync),
    .post_href  (post_href),
    .post_de    (post_de),
    .monoc      (monoc),
    .cur_thresh (cur_thresh),
    .thresh_upd (thresh_upd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    de = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Frame start, then check the threshold and its change pulse.
  task automatic rise_chk(input string tag, input logic [7:0] exp_thr, input logic exp_upd);
    vs = 1'b1;
    tick();
    chk({tag, "_thr"}, cur_thresh, exp_thr);
    chk({tag, "_upd"}, thresh_upd, exp_upd);
  endtask

  task automatic frame_end();
    vs = 1'b0;
    hr = 1'b0;
    de = 1'b0;
    tick();
  endtask

  // href low for one cycle so the next pixel opens a new line.
  task automatic line_start();
    hr = 1'b0;
    de = 1'b0;
    tick();
    hr = 1'b1;
  endtask

  task automatic pix(input logic [7:0] v);
    de = 1'b1;
    d  = v;
    tick();
  endtask

  task automatic pix_chk(input string tag, input logic [7:0] v, input logic exp);
    pix(v);
    chk(tag, monoc, exp);
  endtask

  initial begin
    // Reset with live-looking inputs; outputs must stay cleared.
    vs = 1'b1; hr = 1'b1; de = 1'b1; d = 8'd5;
    repeat (3) tick();
    chk("rst_post_vsync", post_vsync, 0);
    chk("rst_post_de", post_de, 0);
    chk("rst_monoc", monoc, 0);
    chk("rst_upd", thresh_upd, 0);
    chk("rst_thresh", cur_thresh, 32);
    rst = 1'b0; vs = 1'b0; hr = 1'b0; de = 1'b0;
    idle(3);

    // Fixed threshold 32; mid-frame config changes must be ignored.
    aut = 1'b0; th = 8'd32; inv = 1'b0;
    rise_chk("fix1", 8'd32, 1'b0);
    inv = 1'b1; th = 8'd200;
    line_start();
    pix_chk("fix_p31", 8'd31, 1'b1);
    chk("fix_post_de", post_de, 1);
    chk("fix_post_vsync", post_vsync, 1);
    pix_chk("fix_p0", 8'd0, 1'b1);
    pix_chk("fix_p255", 8'd255, 1'b0);
    pix_chk("fix_p32", 8'd32, 1'b0);
    de = 1'b0; d = 8'd0;
    tick();
    chk("fix_blank_monoc", monoc, 0);
    chk("fix_blank_de", post_de, 0);
    frame_end();
    idle(3);

    // Inverted output.
    th = 8'd32; inv = 1'b1;
    rise_chk("inv", 8'd32, 1'b0);
    line_start();
    pix_chk("inv_p31", 8'd31, 1'b0);
    pix_chk("inv_p0", 8'd0, 1'b0);
    pix_chk("inv_p255", 8'd255, 1'b1);
    pix_chk("inv_p32", 8'd32, 1'b1);
    frame_end();
    idle(3);

    // Fixed threshold change produces a single pulse.
    th = 8'd50; inv = 1'b0;
    rise_chk("fix50", 8'd50, 1'b1);
    tick();
    chk("fix50_upd_off", thresh_upd, 0);
    line_start();
    pix_chk("fix50_p50", 8'd50, 1'b0);
    pix_chk("fix50_p49", 8'd49, 1'b1);
    frame_end();
    idle(3);

    // Auto: first frame has no mean yet; 100 pixels of 80 -> mean 80.
    aut = 1'b1; th = 8'd32;
    rise_chk("auto1", 8'd50, 1'b0);
    line_start();
    for (int i = 0; i < 100; i++) pix(8'd80);
    frame_end();
    idle(40);
    rise_chk("auto2", 8'd80, 1'b1);
    tick();
    chk("auto2_upd_off", thresh_upd, 0);
    line_start();
    pix_chk("auto2_p80", 8'd80, 1'b0);
    pix_chk("auto2_p79", 8'd79, 1'b1);
    frame_end();
    idle(40);

    // Mean of {80,79} = 79; this frame has no pixels at all.
    rise_chk("auto3", 8'd79, 1'b1);
    idle(10);
    frame_end();
    idle(40);
    rise_chk("nopix", 8'd79, 1'b0);

    // Frame A: ten pixels of 200, then only 3 cycles of blanking.
    line_start();
    for (int i = 0; i < 10; i++) pix(8'd200);
    frame_end();
    idle(2);
    rise_chk("shortB", 8'd79, 1'b0);
    // Frame B: pixels 10,20,30,41 -> floor(101/4) = 25.
    idle(30);
    line_start();
    pix(8'd10);
    pix(8'd20);
    pix(8'd30);
    pix_chk("shortB_p41", 8'd41, 1'b1);
    frame_end();
    idle(2);
    rise_chk("shortC", 8'd200, 1'b1);
    idle(40);
    frame_end();
    idle(5);
    rise_chk("shortD", 8'd25, 1'b1);
    line_start();
    pix_chk("shortD_p25", 8'd25, 1'b0);
    pix_chk("shortD_p24", 8'd24, 1'b1);
    frame_end();

    // Reset while D's mean is being divided; the result must be lost.
    idle(10);
    rst = 1'b1; vs = 1'b1; hr = 1'b1; de = 1'b1; d = 8'd5;
    tick();
    chk("divrst_post_vsync", post_vsync, 0);
    chk("divrst_post_href", post_href, 0);
    chk("divrst_monoc", monoc, 0);
    chk("divrst_upd", thresh_upd, 0);
    chk("divrst_thresh", cur_thresh, 32);
    rst = 1'b0; vs = 1'b0; hr = 1'b0; de = 1'b0;
    idle(40);
    rise_chk("afterrst", 8'd32, 1'b0);
    line_start();
    pix_chk("afterrst_p32", 8'd32, 1'b0);
    pix_chk("afterrst_p31", 8'd31, 1'b1);
    frame_end();
    idle(40);

`ifdef BINARIZATION_HYST_EN
    aut = 1'b0; th = 8'd100; hy = 8'd4;
    rise_chk("hyst", 8'd100, 1'b1);
    line_start();
    pix_chk("hyst_p90", 8'd90, 1'b1);
    pix_chk("hyst_p102", 8'd102, 1'b1);
    pix_chk("hyst_p104", 8'd104, 1'b1);
    pix_chk("hyst_p110", 8'd110, 1'b0);
    pix_chk("hyst_p97", 8'd97, 1'b0);
    line_start();
    pix_chk("hyst_p101", 8'd101, 1'b0);
    frame_end();
    idle(3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
